// File: rtl/tile_wr_arb_pkg.sv
// Shared helpers for the tile write-channel arbiter.
package tile_wr_arb_pkg;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_wr_arb_fifo.sv
// W-order FIFO: remembers which requester owns each accepted AW until its WLAST.
module tile_wr_arb_fifo
  import tile_wr_arb_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth = idx_width(Depth);
  localparam int unsigned CntWidth = $clog2(Depth) + 1;

  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  count_q;
  logic [DataWidth-1:0] mem_q [Depth];

  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  pop_on_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/tile_wr_arbiter.sv
// Shares one AXI AW+W path among NumInp requesters: round-robin AW, W locked in AW order.
module tile_wr_arbiter
  import tile_wr_arb_pkg::*;
#(
  parameter int unsigned NumInp   = 2,
  parameter int unsigned MaxWTxns = 4,
  parameter int unsigned AwWidth  = 64,
  parameter int unsigned WWidth   = 577,
  parameter int unsigned SrcWidth = idx_width(NumInp)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumInp-1:0]                aw_valid_i,
  output logic [NumInp-1:0]                aw_ready_o,
  input  logic [NumInp-1:0][AwWidth-1:0]   aw_i,
  input  logic [NumInp-1:0]                w_valid_i,
  output logic [NumInp-1:0]                w_ready_o,
  input  logic [NumInp-1:0][WWidth-1:0]    w_i,
  output logic                             aw_valid_o,
  input  logic                             aw_ready_i,
  output logic [AwWidth-1:0]               aw_o,
  output logic [SrcWidth-1:0]              aw_src_o,
  output logic                             w_valid_o,
  input  logic                             w_ready_i,
  output logic [WWidth-1:0]                w_o,
  output logic                             busy_o
);

  localparam int unsigned SumWidth = SrcWidth + 1;

  logic [SrcWidth-1:0] rr_q, lock_idx_q, sel, head;
  logic                lock_q, sel_valid;
  logic                fifo_full, fifo_empty;
  logic                aw_hs, w_last_hs;

  // Winner selection: a held grant wins outright, otherwise search from rr_q with wrap.
  always_comb begin
    logic [SumWidth-1:0] sum;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sel       = '0;
    sel_valid = 1'b0;
    sum       = '0;
    if (!fifo_full) begin
      if (lock_q) begin
        sel       = lock_idx_q;
        sel_valid = aw_valid_i[lock_idx_q];
      end else begin
        for (int i = 0; i < NumInp; i++) begin
          // NOTE: blocking assignments here since later iterations read the updated values.
          sum = {1'b0, rr_q} + SumWidth'(i);
          if (sum >= SumWidth'(NumInp)) sum = sum - SumWidth'(NumInp);
          if (!sel_valid && aw_valid_i[sum[SrcWidth-1:0]]) begin
            sel_valid = 1'b1;
            sel       = sum[SrcWidth-1:0];
          end
        end
      end
    end
  end

  assign aw_valid_o = sel_valid;
  assign aw_src_o   = sel_valid ? sel : '0;
  assign aw_o       = sel_valid ? aw_i[sel] : '0;
  assign aw_hs      = sel_valid && aw_ready_i;

  always_comb begin
    aw_ready_o = '0;
    if (sel_valid) aw_ready_o[sel] = aw_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (aw_hs) rr_q <= (sel == SrcWidth'(NumInp - 1)) ? '0 : sel + SrcWidth'(1);
      lock_q     <= sel_valid && !aw_ready_i;
      lock_idx_q <= sel;
    end
  end

  // W beats only flow for the requester at the FIFO head; early W is held off.
  always_comb begin
    w_valid_o = 1'b0;
    w_o       = '0;
    w_ready_o = '0;
    if (!fifo_empty) begin
      w_valid_o       = w_valid_i[head];
      w_o             = w_i[head];
      w_ready_o[head] = w_ready_i;
    end
  end

  assign w_last_hs = w_valid_o && w_ready_i && w_o[0];
  assign busy_o    = !fifo_empty || lock_q;

  tile_wr_arb_fifo #(
    .Depth     (MaxWTxns),
    .DataWidth (SrcWidth)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .pop_i   (w_last_hs),
    .data_i  (sel),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_tile_wr_arbiter.sv
// Directed bench for tile_wr_arbiter with a queue-based reference model checked every cycle.
module tb_tile_wr_arbiter;

  localparam int N    = 3;
  localparam int MAXW = 4;
  localparam int AW   = 16;
  localparam int WW   = 9;
  localparam int SW   = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [N-1:0]        aw_valid_i = '0;
  logic [N-1:0]        aw_ready_o;
  logic [N-1:0][AW-1:0] aw_i = '0;
  logic [N-1:0]        w_valid_i = '0;
  logic [N-1:0]        w_ready_o;
  logic [N-1:0][WW-1:0] w_i = '0;
  logic                aw_valid_o;
  logic                aw_ready_i = 1'b0;
  logic [AW-1:0]       aw_o;
  logic [SW-1:0]       aw_src_o;
  logic                w_valid_o;
  logic                w_ready_i = 1'b0;
  logic [WW-1:0]       w_o;
  logic                busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  tile_wr_arbiter #(
    .NumInp   (N),
    .MaxWTxns (MAXW),
    .AwWidth  (AW),
    .WWidth   (WW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .aw_i       (aw_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .w_i        (w_i),
    .aw_valid_o (aw_valid_o),
    .aw_ready_i (aw_ready_i),
    .aw_o       (aw_o),
    .aw_src_o   (aw_src_o),
    .w_valid_o  (w_valid_o),
    .w_ready_i  (w_ready_i),
    .w_o        (w_o),
    .busy_o     (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending W owners as a queue, round-robin start as an integer.
  int  m_rr = 0;
  bit  m_lock = 0;
  int  m_lock_idx = 0;
  int  m_q[$];
  logic e_av;
  int  e_ai;
  int  e_h;
  logic e_wv;
  int  dut_grants[$];
  int  dut_wdone[$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_rr = 0;
      m_lock = 0;
      m_q.delete();
    end
    e_av = 1'b0;
    e_ai = 0;
    if (m_q.size() < MAXW) begin
      if (m_lock) begin
        e_av = aw_valid_i[m_lock_idx];
        e_ai = m_lock_idx;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!e_av && aw_valid_i[(m_rr + k) % N]) begin
            e_av = 1'b1;
            e_ai = (m_rr + k) % N;
          end
        end
      end
    end
    check("aw_valid", 64'(aw_valid_o), 64'(e_av));
    check("aw_src", 64'(aw_src_o), e_av ? 64'(e_ai) : 64'd0);
    check("aw_payload", 64'(aw_o), e_av ? 64'(aw_i[e_ai]) : 64'd0);
    check("aw_ready_vec", 64'(aw_ready_o), (e_av && aw_ready_i) ? 64'(1 << e_ai) : 64'd0);
    e_wv = 1'b0;
    e_h  = 0;
    if (m_q.size() > 0) begin
      e_h  = m_q[0];
      e_wv = w_valid_i[e_h];
      check("w_payload", 64'(w_o), 64'(w_i[e_h]));
      check("w_ready_vec", 64'(w_ready_o), w_ready_i ? 64'(1 << e_h) : 64'd0);
    end else begin
      check("w_payload", 64'(w_o), 64'd0);
      check("w_ready_vec", 64'(w_ready_o), 64'd0);
    end
    check("w_valid", 64'(w_valid_o), 64'(e_wv));
    check("busy", 64'(busy_o), 64'((m_q.size() > 0) || m_lock));

    if (rst_ni) begin
      if (aw_valid_o && aw_ready_i) dut_grants.push_back(int'(aw_src_o));
      if (w_valid_o && w_ready_i && w_o[0])
        for (int k = 0; k < N; k++) if (w_ready_o[k]) dut_wdone.push_back(k);
      if (e_wv && w_ready_i && w_i[e_h][0]) void'(m_q.pop_front());
      if (e_av && aw_ready_i) begin
        m_q.push_back(e_ai);
        m_rr = (e_ai + 1) % N;
      end
      m_lock     = e_av && !aw_ready_i;
      m_lock_idx = e_ai;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    aw_valid_i = '0;
    w_valid_i  = '0;
    aw_ready_i = 1'b0;
    w_ready_i  = 1'b0;
    rst_ni     = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    dut_grants.delete();
    dut_wdone.delete();
  endtask

  task automatic drain();
    aw_ready_i = 1'b1;
    w_ready_i  = 1'b1;
    for (int r = 0; r < N; r++) begin
      w_valid_i[r] = 1'b1;
      w_i[r]       = {8'(8'hD0 + r), 1'b1};
    end
    for (int n = 0; n < 20 && busy_o; n++) step();
    check("drain_done", 64'(busy_o), 64'd0);
    w_valid_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 0, 1, 2};

    // Reset state
    #1;
    check("rst_aw_valid", 64'(aw_valid_o), 64'd0);
    check("rst_aw_src", 64'(aw_src_o), 64'd0);
    check("rst_w_valid", 64'(w_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_readies", 64'({aw_ready_o, w_ready_o}), 64'd0);
    repeat (2) step();
    rst_ni = 1'b1;

    // Single requester, 4-beat burst; W offered alongside AW must wait a cycle
    aw_valid_i[0] = 1'b1;
    aw_i[0]       = 16'hA000;
    aw_ready_i    = 1'b1;
    w_ready_i     = 1'b1;
    w_valid_i[0]  = 1'b1;
    w_i[0]        = {8'd1, 1'b0};
    #1;
    check("s1_src", 64'(aw_src_o), 64'd0);
    check("s1_aw_ready", 64'(aw_ready_o), 64'b001);
    check("s1_no_w_yet", 64'(w_valid_o), 64'd0);
    step();
    aw_valid_i[0] = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      w_i[0] = {8'(b), (b == 4)};
      #1;
      check("s1_w_valid", 64'(w_valid_o), 64'd1);
      check("s1_w_data", 64'(w_o), 64'({8'(b), (b == 4)}));
      if (b == 4) check("s1_busy_last", 64'(busy_o), 64'd1);
      step();
    end
    w_valid_i[0] = 1'b0;
    #1;
    check("s1_busy_after", 64'(busy_o), 64'd0);

    // Fairness with all three requesting continuously
    apply_reset();
    aw_ready_i = 1'b1;
    w_ready_i  = 1'b1;
    for (int r = 0; r < N; r++) begin
      aw_valid_i[r] = 1'b1;
      aw_i[r]       = 16'(16'h1000 * (r + 1));
      w_valid_i[r]  = 1'b1;
      w_i[r]        = {8'(8'h10 + r), 1'b1};
    end
    repeat (6) step();
    aw_valid_i = '0;
    drain();
    check("s2_grant_count", 64'(dut_grants.size()), 64'd6);
    check("s2_wdone_count", 64'(dut_wdone.size()), 64'd6);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++)
      check("s2_grant_order", 64'(dut_grants[i]), 64'(exp_order[i]));
    for (int i = 0; i < 6 && i < dut_wdone.size(); i++)
      check("s2_w_order", 64'(dut_wdone[i]), 64'(exp_order[i]));

    // Stall stability: req1 held 5 cycles, req0 joins in cycle 2
    apply_reset();
    aw_valid_i[1] = 1'b1;
    aw_i[1]       = 16'hB111;
    aw_i[0]       = 16'hC000;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) aw_valid_i[0] = 1'b1;
      #1;
      check("s3_src_held", 64'(aw_src_o), 64'd1);
      check("s3_payload_held", 64'(aw_o), 64'hB111);
      step();
    end
    aw_ready_i = 1'b1;
    #1;
    check("s3_hs_src", 64'(aw_src_o), 64'd1);
    step();
    aw_valid_i[1] = 1'b0;
    #1;
    check("s3_next_src", 64'(aw_src_o), 64'd0);
    step();
    aw_valid_i[0] = 1'b0;
    drain();

    // FIFO full: four AWs with no W, the fifth waits for a WLAST pop
    apply_reset();
    aw_valid_i[0] = 1'b1;
    aw_i[0]       = 16'h4444;
    aw_ready_i    = 1'b1;
    repeat (4) step();
    #1;
    check("s4_full_ready", 64'(aw_ready_o), 64'd0);
    check("s4_full_valid", 64'(aw_valid_o), 64'd0);
    check("s4_full_busy", 64'(busy_o), 64'd1);
    step();
    w_ready_i    = 1'b1;
    w_valid_i[0] = 1'b1;
    w_i[0]       = {8'h77, 1'b1};
    #1;
    check("s4_pop_cycle_ready", 64'(aw_ready_o), 64'd0);
    step();
    check("s4_after_pop_ready", 64'(aw_ready_o), 64'b001);
    step();
    aw_valid_i[0] = 1'b0;
    drain();

    // W before AW on req2
    apply_reset();
    aw_ready_i   = 1'b1;
    w_ready_i    = 1'b1;
    w_valid_i[2] = 1'b1;
    w_i[2]       = {8'h21, 1'b0};
    for (int c = 0; c < 3; c++) begin
      #1;
      check("s5_early_w_ready", 64'(w_ready_o), 64'd0);
      step();
    end
    aw_valid_i[2] = 1'b1;
    aw_i[2]       = 16'h2222;
    #1;
    check("s5_src", 64'(aw_src_o), 64'd2);
    check("s5_hs_w_ready", 64'(w_ready_o), 64'd0);
    step();
    aw_valid_i[2] = 1'b0;
    check("s5_w_ready_on", 64'(w_ready_o), 64'b100);
    check("s5_w_data", 64'(w_o), 64'h042);
    step();
    w_i[2] = {8'h22, 1'b1};
    check("s5_last_valid", 64'(w_valid_o), 64'd1);
    step();
    w_valid_i[2] = 1'b0;
    check("s5_busy_after", 64'(busy_o), 64'd0);

    // Reset during beat 2 of a req1 burst, then rr restarts at 0
    aw_valid_i[1] = 1'b1;
    aw_i[1]       = 16'h1111;
    w_valid_i[1]  = 1'b1;
    w_i[1]        = {8'h01, 1'b0};
    #1;
    check("s6_src", 64'(aw_src_o), 64'd1);
    step();
    aw_valid_i[1] = 1'b0;
    step();
    w_i[1] = {8'h02, 1'b0};
    #2;
    rst_ni = 1'b0;
    #1;
    check("s6_rst_w_valid", 64'(w_valid_o), 64'd0);
    check("s6_rst_w_ready", 64'(w_ready_o), 64'd0);
    check("s6_rst_busy", 64'(busy_o), 64'd0);
    check("s6_rst_aw_valid", 64'(aw_valid_o), 64'd0);
    repeat (2) step();
    w_valid_i = '0;
    rst_ni    = 1'b1;
    aw_valid_i[0] = 1'b1;
    aw_valid_i[2] = 1'b1;
    aw_i[0]       = 16'h0A0A;
    aw_i[2]       = 16'h2A2A;
    #1;
    check("s6_first_src", 64'(aw_src_o), 64'd0);
    check("s6_first_payload", 64'(aw_o), 64'h0A0A);
    step();
    aw_valid_i[0] = 1'b0;
    check("s6_second_src", 64'(aw_src_o), 64'd2);
    step();
    aw_valid_i[2] = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
